// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file.
//   XLEN_D / NREGS_D : default data width and register count
//   reg_addr_t       : register index at the default size
//   xword_t          : data word at the default width
//   be_merge()       : byte-enable merge of a new word into an old one
package regfile_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;
  localparam int unsigned AW_D    = $clog2(NREGS_D);

  // be_merge works on a wide container so any XLEN up to XLEN_MAX can use it.
  // Callers zero-extend into it and truncate back out.
  localparam int unsigned XLEN_MAX = 256;
  localparam int unsigned BE_MAX   = XLEN_MAX / 8;

  typedef logic [AW_D-1:0]     reg_addr_t;
  typedef logic [XLEN_D-1:0]   xword_t;
  typedef logic [XLEN_MAX-1:0] wide_word_t;
  typedef logic [BE_MAX-1:0]   wide_be_t;

  // Bytes with be[b]=1 come from new_w, the rest from old_w.
  function automatic wide_word_t be_merge(input wide_word_t old_w, input wide_word_t new_w,
                                          input wide_be_t be);
    wide_word_t res;
    res = old_w;
    for (int unsigned b = 0; b < BE_MAX; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_fwd.sv
// Forwarding network for one read port.
// Merges every same-cycle write that targets the read address into the stored word; later
// ports are applied after earlier ones so the highest-numbered port wins each byte.
//   rd_addr_i  : register being read
//   stored_i   : current stored contents of that register
//   wr_en_i    : write strobes, one per write port
//   wr_addr_i  : write destinations, port p in [p*AW +: AW]
//   wr_be_i    : byte enables, port p in [p*BW +: BW]
//   wr_data_i  : write data, port p in [p*XLEN +: XLEN]
//   fwd_data_o : stored word with same-cycle writes merged in
//   wr_hit_o   : 1 when any write port targets rd_addr_i this cycle
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_D,
  parameter  int unsigned NREGS  = NREGS_D,
  parameter  int unsigned NWRITE = 1,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned BW     = XLEN / 8
) (
  input  logic [AW-1:0]          rd_addr_i,
  input  logic [XLEN-1:0]        stored_i,
  input  logic [NWRITE-1:0]      wr_en_i,
  input  logic [NWRITE*AW-1:0]   wr_addr_i,
  input  logic [NWRITE*BW-1:0]   wr_be_i,
  input  logic [NWRITE*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]        fwd_data_o,
  output logic                   wr_hit_o
);

  always_comb begin
    fwd_data_o = stored_i;
    wr_hit_o   = 1'b0;
    for (int unsigned p = 0; p < NWRITE; p++) begin
      if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
        wr_hit_o   = 1'b1;
        fwd_data_o = XLEN'(be_merge(XLEN_MAX'(fwd_data_o),
                                    XLEN_MAX'(wr_data_i[p*XLEN +: XLEN]),
                                    BE_MAX'(wr_be_i[p*BW +: BW])));
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file with write-through bypass, byte-enable writes and a
// per-register busy scoreboard. Reads are combinational and see same-cycle writes.
//   clk      : clock, all state updates on the rising edge
//   rstn     : synchronous active-low reset; clears data and busy bits
//   rd_addr  : read addresses, port i in [i*AW +: AW]
//   rd_data  : read data, port i in [i*XLEN +: XLEN]
//   rd_busy  : per read port, register has a pending (reserved, not yet written) value
//   wr_en    : write strobes per write port
//   wr_addr  : write destinations per write port
//   wr_be    : byte enables per write port
//   wr_data  : write data per write port
//   rsv_en   : reserve rsv_addr (set its busy bit)
//   rsv_addr : register to reserve
//   flush    : clear every busy bit, data untouched
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_D,
  parameter  int unsigned NREGS    = NREGS_D,
  parameter  int unsigned NREAD    = 2,
  parameter  int unsigned NWRITE   = 1,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS),
  localparam int unsigned BW       = XLEN / 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*BW-1:0]   wr_be,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic                   flush
);

  localparam bit HasZero = (ZERO_REG != 0);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] wr_hit;

  // Per-register write merge; ports applied in ascending order so the highest port wins a byte.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      mem_d[r]  = mem_q[r];
      wr_hit[r] = 1'b0;
      for (int unsigned p = 0; p < NWRITE; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          mem_d[r]  = XLEN'(be_merge(XLEN_MAX'(mem_d[r]),
                                     XLEN_MAX'(wr_data[p*XLEN +: XLEN]),
                                     BE_MAX'(wr_be[p*BW +: BW])));
        end
      end
      if (HasZero && (r == 0)) begin
        mem_d[r] = '0;
      end
    end
  end

  // Scoreboard priority: flush, then reserve (new producer), then write completion.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (rsv_en && (rsv_addr == AW'(r)) && !(HasZero && (r == 0))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] fwd_data;
    logic            hit;
    logic            is_zero;

    assign addr    = rd_addr[i*AW +: AW];
    assign is_zero = HasZero && (addr == '0);

    regfile_fwd #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWRITE (NWRITE)
    ) u_fwd (
      .rd_addr_i  (addr),
      .stored_i   (mem_q[addr]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_be_i    (wr_be),
      .wr_data_i  (wr_data),
      .fwd_data_o (fwd_data),
      .wr_hit_o   (hit)
    );

    assign rd_data[i*XLEN +: XLEN] = is_zero ? '0 : fwd_data;
    // A write in flight retires the pending value for readers in the same cycle.
    assign rd_busy[i] = ~is_zero & busy_q[addr] & ~hit;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance A: defaults (NWRITE=1, ZERO_REG=1)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [3:0]  a_wr_be;
  logic [31:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;

  // Instance B: NWRITE=2, ZERO_REG=0
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [7:0]  b_wr_be;
  logic [63:0] b_wr_data;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_addr;
  logic        b_flush;

  regfile_mp_sb u_dut_a (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_be    (a_wr_be),
    .wr_data  (a_wr_data),
    .rsv_en   (a_rsv_en),
    .rsv_addr (a_rsv_addr),
    .flush    (a_flush)
  );

  regfile_mp_sb #(
    .NWRITE   (2),
    .ZERO_REG (0)
  ) u_dut_b (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_be    (b_wr_be),
    .wr_data  (b_wr_data),
    .rsv_en   (b_rsv_en),
    .rsv_addr (b_rsv_addr),
    .flush    (b_flush)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_be = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_be = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    a_rd_addr = {5'd31, 5'd5};
    #1;
    chk("rst_data_p0", a_rd_data[31:0], 32'h0);
    chk("rst_data_p1", a_rd_data[63:32], 32'h0);
    chk("rst_busy", a_rd_busy, 2'b00);

    // 1: write then reset clears data and busy
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_be = 4'hF; a_wr_data = 32'hDEADBEEF;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd10;
    tick();
    a_wr_en = 1'b0; a_rsv_en = 1'b0;
    a_rd_addr = {5'd10, 5'd5};
    #1;
    chk("pre_rst_r5", a_rd_data[31:0], 32'hDEADBEEF);
    chk("pre_rst_busy", a_rd_busy, 2'b10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    chk("post_rst_r5", a_rd_data[31:0], 32'h0);
    chk("post_rst_busy", a_rd_busy, 2'b00);

    // 2: byte-enable write with same-cycle bypass
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_be = 4'hF; a_wr_data = 32'h11223344;
    tick();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd7, 5'd0};
    #1;
    chk("r7_init", a_rd_data[63:32], 32'h11223344);
    a_wr_en = 1'b1; a_wr_be = 4'b0101; a_wr_data = 32'hAABBCCDD;
    #1;
    chk("be_bypass", a_rd_data[63:32], 32'h11BB33DD);
    tick();
    a_wr_en = 1'b0;
    #1;
    chk("be_stored", a_rd_data[63:32], 32'h11BB33DD);

    // 3: zero register
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_be = 4'hF; a_wr_data = 32'hFFFFFFFF;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_rd_addr = {5'd7, 5'd0};
    #1;
    chk("zero_same", a_rd_data[31:0], 32'h0);
    chk("zero_busy_same", a_rd_busy[0], 1'b0);
    tick();
    a_wr_en = 1'b0; a_rsv_en = 1'b0;
    #1;
    chk("zero_after", a_rd_data[31:0], 32'h0);
    chk("zero_busy_after", a_rd_busy[0], 1'b0);

    // 5: scoreboard
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    a_rd_addr = {5'd7, 5'd9};
    #1;
    chk("rsv_not_yet", a_rd_busy[0], 1'b0);
    tick();
    a_rsv_en = 1'b0;
    #1;
    chk("rsv_visible", a_rd_busy[0], 1'b1);
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_be = 4'hF; a_wr_data = 32'h00000099;
    a_rsv_en = 1'b1;
    #1;
    chk("wr_rsv_inflight", a_rd_busy[0], 1'b0);
    tick();
    a_wr_en = 1'b0; a_rsv_en = 1'b0;
    #1;
    chk("rsv_beats_wr", a_rd_busy[0], 1'b1);
    chk("r9_data", a_rd_data[31:0], 32'h00000099);
    a_wr_en = 1'b1; a_wr_data = 32'h0000009A;
    #1;
    chk("wr_clears_same", a_rd_busy[0], 1'b0);
    chk("r9_bypass", a_rd_data[31:0], 32'h0000009A);
    tick();
    a_wr_en = 1'b0;
    #1;
    chk("wr_clears_after", a_rd_busy[0], 1'b0);

    // 6: flush beats a same-cycle reserve
    a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
    tick();
    a_rsv_addr = 5'd6;
    tick();
    a_rsv_en = 1'b0;
    a_rd_addr = {5'd6, 5'd4};
    #1;
    chk("two_busy", a_rd_busy, 2'b11);
    a_flush = 1'b1; a_rsv_en = 1'b1; a_rsv_addr = 5'd8;
    #1;
    chk("flush_registered", a_rd_busy, 2'b11);
    tick();
    a_flush = 1'b0; a_rsv_en = 1'b0;
    #1;
    chk("flush_clears", a_rd_busy, 2'b00);
    a_rd_addr = {5'd7, 5'd8};
    #1;
    chk("flush_beats_rsv", a_rd_busy, 2'b00);
    chk("flush_data_kept", a_rd_data[63:32], 32'h11BB33DD);

    // 3b: ordinary register 0
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd0}; b_wr_be = {4'h0, 4'hF};
    b_wr_data = {32'h0, 32'hFFFFFFFF};
    b_rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_ord_same", b_rd_data[31:0], 32'hFFFFFFFF);
    tick();
    b_wr_en = 2'b00;
    #1;
    chk("r0_ord_after", b_rd_data[31:0], 32'hFFFFFFFF);

    // 4: two-port conflict, per-byte merge
    b_wr_en = 2'b11; b_wr_addr = {5'd3, 5'd3}; b_wr_be = {4'b0010, 4'hF};
    b_wr_data = {32'h0000BB00, 32'h000000AA};
    b_rd_addr = {5'd0, 5'd3};
    #1;
    chk("conflict_same", b_rd_data[31:0], 32'h0000BBAA);
    tick();
    b_wr_en = 2'b00;
    #1;
    chk("conflict_after", b_rd_data[31:0], 32'h0000BBAA);

    // Overlapping byte: port 1 wins byte 0
    b_wr_en = 2'b11; b_wr_addr = {5'd12, 5'd12}; b_wr_be = {4'b0001, 4'hF};
    b_wr_data = {32'h00000022, 32'h11111111};
    b_rd_addr = {5'd12, 5'd0};
    #1;
    chk("overlap_same", b_rd_data[63:32], 32'h11111122);
    tick();
    b_wr_en = 2'b00;
    #1;
    chk("overlap_after", b_rd_data[63:32], 32'h11111122);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
